// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller.
// MW_QUICK_START_EN (in the RTL files) enables the 30-second quick-start/add feature.
package microwave_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_COOK  = ST_COOK,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t mins;
        bcd_t tens;
        bcd_t ones;
    } bcd_time_t;

    localparam int BCD_MAX_TENS = 5;
    localparam int QUICK_SECS   = 30;
    localparam int MAX_SECS     = 599;

    // Tens digits above 5 are legal on entry, so go through plain seconds and renormalise.
    function automatic bcd_time_t add_secs_sat(bcd_time_t t, int add);
        int s;
        bcd_time_t r;
        s = int'(t.mins) * 60 + int'(t.tens) * 10 + int'(t.ones) + add;
        if (s > MAX_SECS) s = MAX_SECS;
        r.mins = 4'(s / 60);
        r.tens = 4'((s % 60) / 10);
        r.ones = 4'(s % 10);
        return r;
    endfunction

endpackage

// File: rtl/microwave_controller_if.sv
// Encoder / keypad / door signals and display outputs of the microwave controller.
interface microwave_controller_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1hz;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       enablen;
    logic       mag_on;
    logic       done;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    modport master (
        output D, loadn, pgt_1hz, start, stop_clear, door_closed,
        input  enablen, mag_on, done, min_bcd, sec_tens, sec_ones
    );

    modport slave (
        input  D, loadn, pgt_1hz, start, stop_clear, door_closed,
        output enablen, mag_on, done, min_bcd, sec_tens, sec_ones
    );
endinterface

// File: rtl/microwave_controller_bcd_down_counter.sv
// Three-digit M:SS BCD register: clear, parallel load, keypad shift-in and
// decrement with borrow. Never decrements below 0:00.
module bcd_down_counter
    import microwave_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      load,
    input  logic      shift,
    input  logic      dec,
    input  bcd_t      digit,
    input  bcd_time_t load_val,
    output bcd_time_t value,
    output logic      zero,
    output logic      at_one
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (shift) begin
            value <= {value.tens, value.ones, digit};
        end else if (dec && !zero) begin
            if (value.ones != 4'd0) begin
                value.ones <= value.ones - 4'd1;
            end else begin
                value.ones <= 4'd9;
                if (value.tens != 4'd0) begin
                    value.tens <= value.tens - 4'd1;
                end else begin
                    value.tens <= 4'(BCD_MAX_TENS);
                    value.mins <= value.mins - 4'd1;
                end
            end
        end
    end

    assign zero   = (value == '0);
    assign at_one = (value == {4'd0, 4'd0, 4'd1});

endmodule

// File: rtl/microwave_controller.sv
// Microwave sequencer: keypad capture, 1 Hz countdown, magnetron/done control.
// Optional feature: define MW_QUICK_START_EN for quick start (0:30) and +30 s while cooking.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int DONE_TICKS = 3
) (
    input logic                  clk,
    input logic                  rst,
    microwave_controller_if.slave bus
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DN_W  = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    state_t            state, state_nx;
    logic              loadn_q, pgt_q;
    logic              digit_stb, tick;
    logic [DIV_W-1:0]  div_cnt, div_nx;
    logic [DN_W-1:0]   done_cnt, done_nx;
    logic              clr, load, shift, dec;
    bcd_time_t         tval, load_val;
    logic              zero, at_one;

    assign digit_stb = loadn_q & ~bus.loadn;
    assign tick      = ~pgt_q & bus.pgt_1hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            loadn_q  <= 1'b0;
            pgt_q    <= 1'b0;
            div_cnt  <= '0;
            done_cnt <= '0;
        end else begin
            state    <= state_nx;
            loadn_q  <= bus.loadn;
            pgt_q    <= bus.pgt_1hz;
            div_cnt  <= div_nx;
            done_cnt <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        done_nx  = '0;
        clr      = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        dec      = 1'b0;
        load_val = tval;
        case (state)
            S_IDLE: begin
                if (bus.stop_clear) begin
                    clr = 1'b1;
                end else if (bus.start && bus.door_closed && !zero) begin
                    state_nx = S_COOK;
`ifdef MW_QUICK_START_EN
                end else if (bus.start && bus.door_closed) begin
                    load     = 1'b1;
                    load_val = add_secs_sat('0, QUICK_SECS);
                    state_nx = S_COOK;
`endif
                end else if (digit_stb && bus.D <= 4'd9) begin
                    shift = 1'b1;
                end
            end
            S_COOK: begin
                if (bus.stop_clear || !bus.door_closed) begin
                    state_nx = S_PAUSE;
`ifdef MW_QUICK_START_EN
                end else if (bus.start) begin
                    load     = 1'b1;
                    load_val = add_secs_sat(tval, QUICK_SECS);
`endif
                end else if (tick) begin
                    if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
                        div_nx = '0;
                        dec    = 1'b1;
                        // The decrement that lands on 0:00 finishes in the same edge.
                        if (at_one) state_nx = S_DONE;
                    end else begin
                        div_nx = div_cnt + DIV_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (bus.stop_clear) begin
                    clr      = 1'b1;
                    div_nx   = '0;
                    state_nx = S_IDLE;
                end else if (bus.start && bus.door_closed) begin
                    state_nx = S_COOK;
                end
            end
            S_DONE: begin
                done_nx = done_cnt;
                if (bus.stop_clear || !bus.door_closed) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    if (done_cnt == DN_W'(DONE_TICKS - 1)) state_nx = S_IDLE;
                    else done_nx = done_cnt + DN_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    bcd_down_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .shift    (shift),
        .dec      (dec),
        .digit    (bus.D),
        .load_val (load_val),
        .value    (tval),
        .zero     (zero),
        .at_one   (at_one)
    );

    assign bus.mag_on   = (state == S_COOK);
    assign bus.done     = (state == S_DONE);
    assign bus.enablen  = !((state == S_COOK) || (state == S_DONE));
    assign bus.min_bcd  = tval.mins;
    assign bus.sec_tens = tval.tens;
    assign bus.sec_ones = tval.ones;

endmodule

// File: tb/tb_microwave_controller.sv
// Scoreboard bench for microwave_controller: directed scenarios then random traffic,
// predicted by a seconds/digit-level reference model.
module tb_microwave_controller;

    localparam int TICK_DIV   = 1;
    localparam int DONE_TICKS = 3;
    localparam int MI = 0, MC = 1, MP = 2, MD = 3;

    logic clk;
    logic rst;
    microwave_controller_if bus();

    microwave_controller #(.TICK_DIV(TICK_DIV), .DONE_TICKS(DONE_TICKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    en, mag, dn, mi, te, on;
        string tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode, m_mi, m_te, m_on, m_div, m_dc;
    bit m_pl, m_pp;

    function automatic bit m_zero();
        return (m_mi == 0 && m_te == 0 && m_on == 0);
    endfunction

    task automatic m_set_secs(input int s);
        if (s > 599) s = 599;
        m_mi = s / 60;
        m_te = (s % 60) / 10;
        m_on = s % 10;
    endtask

    task automatic mstep();
        bit stb, tk;
        int d;
        if (rst) begin
            m_mode = MI; m_mi = 0; m_te = 0; m_on = 0;
            m_div = 0; m_dc = 0; m_pl = 0; m_pp = 0;
            return;
        end
        stb = m_pl && !bus.loadn;
        tk  = !m_pp && bus.pgt_1hz;
        m_pl = bus.loadn;
        m_pp = bus.pgt_1hz;
        d = int'(bus.D);
        case (m_mode)
            MI: begin
                if (bus.stop_clear) begin
                    m_mi = 0; m_te = 0; m_on = 0;
                end else if (bus.start && bus.door_closed && !m_zero()) begin
                    m_mode = MC;
`ifdef MW_QUICK_START_EN
                end else if (bus.start && bus.door_closed) begin
                    m_set_secs(30);
                    m_mode = MC;
`endif
                end else if (stb && d <= 9) begin
                    m_mi = m_te; m_te = m_on; m_on = d;
                end
            end
            MC: begin
                if (bus.stop_clear || !bus.door_closed) begin
                    m_mode = MP;
`ifdef MW_QUICK_START_EN
                end else if (bus.start) begin
                    m_set_secs(m_mi * 60 + m_te * 10 + m_on + 30);
`endif
                end else if (tk) begin
                    m_div++;
                    if (m_div == TICK_DIV) begin
                        m_div = 0;
                        if (m_on > 0) m_on--;
                        else begin
                            m_on = 9;
                            if (m_te > 0) m_te--;
                            else begin m_te = 5; m_mi--; end
                        end
                        if (m_zero()) begin m_mode = MD; m_dc = 0; end
                    end
                end
            end
            MP: begin
                if (bus.stop_clear) begin
                    m_mi = 0; m_te = 0; m_on = 0; m_div = 0; m_mode = MI;
                end else if (bus.start && bus.door_closed) begin
                    m_mode = MC;
                end
            end
            default: begin
                if (bus.stop_clear || !bus.door_closed) m_mode = MI;
                else if (tk) begin
                    m_dc++;
                    if (m_dc == DONE_TICKS) m_mode = MI;
                end
            end
        endcase
    endtask

    // one clock: predict the post-edge outputs, then advance to just after the edge
    task automatic cyc(input string tag);
        exp_t e;
        mstep();
        e.en  = (m_mode == MC || m_mode == MD) ? 0 : 1;
        e.mag = (m_mode == MC) ? 1 : 0;
        e.dn  = (m_mode == MD) ? 1 : 0;
        e.mi  = m_mi; e.te = m_te; e.on = m_on;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int mi, input int te, input int on);
        chk(name, int'(bus.min_bcd) * 100 + int'(bus.sec_tens) * 10 + int'(bus.sec_ones),
            mi * 100 + te * 10 + on);
    endtask

    task automatic chk_out(input string name, input int en, input int mag, input int dn);
        chk(name, {29'd0, bus.enablen, bus.mag_on, bus.done}, en * 4 + mag * 2 + dn);
    endtask

    task automatic key(input int d);
        bus.D = 4'(d); bus.loadn = 1'b0; cyc("key");
        bus.loadn = 1'b1; cyc("key_rel");
    endtask

    task automatic tick_hi();
        bus.pgt_1hz = 1'b1; cyc("tick");
    endtask

    task automatic tick_lo();
        bus.pgt_1hz = 1'b0; cyc("tick_lo");
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc("start");
        bus.start = 1'b0;
    endtask

    task automatic clear_all();
        bus.stop_clear = 1'b1; cyc("stop1"); cyc("stop2");
        bus.stop_clear = 1'b0;
    endtask

    // scoreboard monitor: one expected response per clock
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (int'(bus.enablen) != e.en || int'(bus.mag_on) != e.mag || int'(bus.done) != e.dn ||
                int'(bus.min_bcd) != e.mi || int'(bus.sec_tens) != e.te || int'(bus.sec_ones) != e.on) begin
                bad++;
                $display("FAIL sb_%s @%0t: got en=%0b mag=%0b done=%0b %0d:%0d%0d expected en=%0d mag=%0d done=%0d %0d:%0d%0d",
                         e.tag, $time, bus.enablen, bus.mag_on, bus.done, bus.min_bcd, bus.sec_tens,
                         bus.sec_ones, e.en, e.mag, e.dn, e.mi, e.te, e.on);
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        bus.D = 4'd0; bus.loadn = 1'b1; bus.pgt_1hz = 1'b0;
        bus.start = 1'b0; bus.stop_clear = 1'b0; bus.door_closed = 1'b1;
        cyc("reset"); cyc("reset");
        chk_out("reset_outs", 1, 0, 0);
        chk_time("reset_time", 0, 0, 0);
        rst = 1'b0;
        cyc("idle");

        // keypad entry 1:30 and first decrement
        key(1); key(3); key(0);
        chk_time("entry_130", 1, 3, 0);
        pulse_start();
        chk_out("cook_outs", 0, 1, 0);
        chk_time("cook_130", 1, 3, 0);
        tick_hi();
        chk_time("first_tick_129", 1, 2, 9);
        tick_lo();
        clear_all();
        chk_out("cleared_idle", 1, 0, 0);
        chk_time("cleared_time", 0, 0, 0);

        // borrow across minutes
        key(1); key(0); key(0);
        pulse_start();
        tick_hi();
        chk_time("borrow_059", 0, 5, 9);
        tick_lo();
        clear_all();

        // reach 0:00, DONE for DONE_TICKS ticks
        key(0); key(0); key(1);
        pulse_start();
        tick_hi();
        chk_out("done_outs", 0, 0, 1);
        chk_time("done_time", 0, 0, 0);
        tick_lo();
        tick_hi(); tick_lo(); tick_hi(); tick_lo();
        chk_out("done_hold", 0, 0, 1);
        tick_hi();
        chk_out("done_exit", 1, 0, 0);
        tick_lo();

        // door open pause and resume
        key(4); key(5);
        pulse_start();
        bus.door_closed = 1'b0; cyc("door_open");
        chk_out("pause_outs", 1, 0, 0);
        chk_time("pause_045", 0, 4, 5);
        bus.door_closed = 1'b1; cyc("door_close");
        pulse_start();
        chk_out("resume_outs", 0, 1, 0);
        key(2);
        chk_time("cook_strobe_ignored", 0, 4, 5);

        // start + stop_clear together in PAUSE
        bus.stop_clear = 1'b1; cyc("to_pause");
        bus.start = 1'b1; cyc("start_stop");
        bus.start = 1'b0; bus.stop_clear = 1'b0;
        chk_out("start_stop_idle", 1, 0, 0);
        chk_time("start_stop_time", 0, 0, 0);

        // invalid digit
        key(7); key(12);
        chk_time("invalid_digit", 0, 0, 7);

        // asynchronous reset mid-COOK
        pulse_start(); cyc("cooking");
        chk_out("pre_reset_cook", 0, 1, 0);
        #5;
        rst = 1'b1;
        #1;
        chk_out("async_reset_outs", 1, 0, 0);
        chk_time("async_reset_time", 0, 0, 0);
        cyc("rst"); cyc("rst");
        rst = 1'b0;
        cyc("idle");

        // start at 0:00
        pulse_start();
`ifdef MW_QUICK_START_EN
        chk_time("quick_030", 0, 3, 0);
        chk_out("quick_cook", 0, 1, 0);
        pulse_start();
        chk_time("quick_100", 1, 0, 0);
        clear_all();
`else
        chk_out("zero_start_idle", 1, 0, 0);
        chk_time("zero_start_time", 0, 0, 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.door_closed = ($urandom_range(0, 19) != 0);
            bus.start       = ($urandom_range(0, 15) == 0);
            bus.stop_clear  = ($urandom_range(0, 40) == 0);
            bus.loadn       = ($urandom_range(0, 3) != 0);
            bus.D           = 4'($urandom_range(0, 15));
            if ((m_mode == MC || m_mode == MD) && $urandom_range(0, 2) == 0)
                bus.pgt_1hz = ~bus.pgt_1hz;
            cyc("rand");
        end

        bus.start = 1'b0; bus.stop_clear = 1'b0; bus.loadn = 1'b1;
        cyc("tail");
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
